// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the backing-memory arbiter.
//   arb_state_t - arbiter FSM states
//   req_id_t    - requester identity, used by the round-robin tie-breaker
//   WORD_BYTES  - bytes per memory word; WORD_OFF is its address shift
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, IC_RD, DC_RD, DC_WR} arb_state_t;

    typedef enum logic {REQ_IC, REQ_DC} req_id_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_OFF   = $clog2(WORD_BYTES);

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side and memory-side signals of the memory arbiter.
//   slave  - arbiter view: requests, addresses, write data and memory read data in;
//            refill data, valid/done pulses, beat index, memory strobes and stall out.
//   master - the caches and memory model (mirror of slave).
interface mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WORDS = 4
);
    // I-cache
    logic                          ic_req_i;
    logic [ADDR_WIDTH-1:0]         ic_addr_i;
    logic [31:0]                   ic_rdata_o;
    logic                          ic_rvalid_o;
    logic                          ic_done_o;
    // D-cache
    logic                          dc_req_i;
    logic                          dc_we_i;
    logic [ADDR_WIDTH-1:0]         dc_addr_i;
    logic [31:0]                   dc_wdata_i;
    logic [$clog2(LINE_WORDS)-1:0] dc_beat_o;
    logic [31:0]                   dc_rdata_o;
    logic                          dc_rvalid_o;
    logic                          dc_done_o;
    // Memory
    logic                          mem_en_o;
    logic                          mem_we_o;
    logic [ADDR_WIDTH-1:0]         mem_addr_o;
    logic [31:0]                   mem_wdata_o;
    logic [31:0]                   mem_rdata_i;
    // Pipeline
    logic                          cache_stall_o;

    modport slave (
        input  ic_req_i, ic_addr_i, dc_req_i, dc_we_i, dc_addr_i, dc_wdata_i, mem_rdata_i,
        output ic_rdata_o, ic_rvalid_o, ic_done_o, dc_beat_o, dc_rdata_o, dc_rvalid_o,
               dc_done_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, cache_stall_o
    );

    modport master (
        output ic_req_i, ic_addr_i, dc_req_i, dc_we_i, dc_addr_i, dc_wdata_i, mem_rdata_i,
        input  ic_rdata_o, ic_rvalid_o, ic_done_o, dc_beat_o, dc_rdata_o, dc_rvalid_o,
               dc_done_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, cache_stall_o
    );

endinterface

// File: rtl/mem_beat_seq.sv
// mem_beat_seq: beat and per-beat cycle counters for one line transfer.
//   clk               - clock
//   clear_i           - synchronous clear, aborts any transfer in progress
//   start_i           - begin a transfer at beat 0 on the next cycle
//   beat_o            - current beat index
//   beat_last_cycle_o - last cycle of the current beat
//   line_last_o       - last cycle of the final beat
module mem_beat_seq #(
    parameter int unsigned LINE_WORDS  = 4,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                          clk,
    input  logic                          clear_i,
    input  logic                          start_i,
    output logic [$clog2(LINE_WORDS)-1:0] beat_o,
    output logic                          beat_last_cycle_o,
    output logic                          line_last_o
);
    localparam int unsigned BW = $clog2(LINE_WORDS);
    localparam int unsigned CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [BW-1:0] BEAT_MAX = BW'(LINE_WORDS - 1);
    localparam logic [CW-1:0] CYC_MAX  = CW'(MEM_LATENCY - 1);

    logic          run_q, run_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [CW-1:0] cyc_q, cyc_d;

    assign beat_o            = beat_q;
    assign beat_last_cycle_o = run_q && (cyc_q == CYC_MAX);
    assign line_last_o       = beat_last_cycle_o && (beat_q == BEAT_MAX);

    always_comb begin
        run_d  = run_q;
        beat_d = beat_q;
        cyc_d  = cyc_q;
        if (start_i) begin
            run_d  = 1'b1;
            beat_d = '0;
            cyc_d  = '0;
        end else if (run_q) begin
            if (cyc_q == CYC_MAX) begin
                cyc_d = '0;
                // Final beat: stop and park at 0 as the arbiter returns to IDLE
                if (beat_q == BEAT_MAX) begin
                    run_d  = 1'b0;
                    beat_d = '0;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end else begin
                cyc_d = cyc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear_i) begin
            run_q  <= 1'b0;
            beat_q <= '0;
            cyc_q  <= '0;
        end else begin
            run_q  <= run_d;
            beat_q <= beat_d;
            cyc_q  <= cyc_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single backing-memory port between I-cache refills and
// D-cache refills/writebacks, one multi-beat line transfer at a time.
//   clk, rst - clock and synchronous active-high reset
//   bus      - mem_arbiter_if.slave: cache requests/responses, memory port, cache_stall_o
// Build option: define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise the
// D-cache always wins a tie.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned LINE_WORDS  = 4,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned BW    = $clog2(LINE_WORDS);
    localparam int unsigned OFF   = BW + WORD_OFF;
    localparam int unsigned TAG_W = ADDR_WIDTH - OFF;

    arb_state_t       state_q, state_d;
    logic [TAG_W-1:0] line_q, line_d;
    logic [BW-1:0]    beat;
    logic             beat_last_cycle;
    logic             line_last;
    logic             busy;
    logic             start;
    logic             dc_wins_tie;
    logic             grant_dc;
    logic             grant_ic;

`ifdef MEM_ARB_RR_EN
    req_id_t last_grant_q, last_grant_d;
    assign dc_wins_tie = (last_grant_q == REQ_IC);
`else
    // The D-cache miss belongs to the older instruction in MEM
    assign dc_wins_tie = 1'b1;
`endif

    assign busy     = (state_q != IDLE);
    assign grant_dc = bus.dc_req_i && (!bus.ic_req_i || dc_wins_tie);
    assign grant_ic = bus.ic_req_i && !grant_dc;
    assign start    = !busy && (grant_dc || grant_ic);

    mem_beat_seq #(
        .LINE_WORDS  (LINE_WORDS),
        .MEM_LATENCY (MEM_LATENCY)
    ) u_beat_seq (
        .clk               (clk),
        .clear_i           (rst),
        .start_i           (start),
        .beat_o            (beat),
        .beat_last_cycle_o (beat_last_cycle),
        .line_last_o       (line_last)
    );

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
`ifdef MEM_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (grant_dc) begin
                    state_d = bus.dc_we_i ? DC_WR : DC_RD;
                    line_d  = bus.dc_addr_i[ADDR_WIDTH-1:OFF];
`ifdef MEM_ARB_RR_EN
                    last_grant_d = REQ_DC;
`endif
                end else if (grant_ic) begin
                    state_d = IC_RD;
                    line_d  = bus.ic_addr_i[ADDR_WIDTH-1:OFF];
`ifdef MEM_ARB_RR_EN
                    last_grant_d = REQ_IC;
`endif
                end
            end
            IC_RD, DC_RD, DC_WR: begin
                if (line_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            line_q  <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= REQ_IC;
`endif
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Outputs decode the registered state and beat counters; read data passes
    // straight through because memory presents it only in the beat's last cycle.
    always_comb begin
        bus.ic_rdata_o    = '0;
        bus.ic_rvalid_o   = 1'b0;
        bus.ic_done_o     = 1'b0;
        bus.dc_beat_o     = '0;
        bus.dc_rdata_o    = '0;
        bus.dc_rvalid_o   = 1'b0;
        bus.dc_done_o     = 1'b0;
        bus.mem_en_o      = busy;
        bus.mem_we_o      = 1'b0;
        bus.mem_addr_o    = '0;
        bus.mem_wdata_o   = '0;
        bus.cache_stall_o = bus.ic_req_i | bus.dc_req_i | busy;
        if (busy) begin
            bus.mem_addr_o = {line_q, beat, {WORD_OFF{1'b0}}};
        end
        unique case (state_q)
            IC_RD: begin
                bus.ic_rvalid_o = beat_last_cycle;
                bus.ic_rdata_o  = beat_last_cycle ? bus.mem_rdata_i : 32'h0;
                bus.ic_done_o   = line_last;
            end
            DC_RD: begin
                bus.dc_beat_o   = beat;
                bus.dc_rvalid_o = beat_last_cycle;
                bus.dc_rdata_o  = beat_last_cycle ? bus.mem_rdata_i : 32'h0;
                bus.dc_done_o   = line_last;
            end
            DC_WR: begin
                bus.dc_beat_o   = beat;
                bus.mem_we_o    = beat_last_cycle;
                bus.mem_wdata_o = bus.dc_wdata_i;
                bus.dc_done_o   = line_last;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with an event scoreboard.
// Each transaction pushes its expected rvalid/write/done events (cycle, address,
// data); a negedge monitor pops and compares them as the DUT pulses.
module tb_mem_arbiter;
    localparam int unsigned AW  = 32;
    localparam int unsigned LW  = 4;
    localparam int unsigned LAT = 2;

    localparam int K_IC_RV   = 0;
    localparam int K_DC_RV   = 1;
    localparam int K_WR      = 2;
    localparam int K_IC_DONE = 3;
    localparam int K_DC_DONE = 4;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   t0;
    ev_t  sb[$];

    mem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WORDS(LW)) bus ();

    mem_arbiter #(
        .ADDR_WIDTH  (AW),
        .LINE_WORDS  (LW),
        .MEM_LATENCY (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory returns a function of the address; the D-cache supplies 0x100+beat.
    assign bus.mem_rdata_i = bus.mem_addr_o ^ 32'hA5A5_A5A5;
    assign bus.dc_wdata_i  = 32'h100 + 32'(bus.dc_beat_o);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected events of a line transfer arbitrated in IDLE at cycle tg.
    task automatic expect_line(input int tg, input bit is_dc, input bit wr,
                               input logic [31:0] base, input int nbeats, input bit with_done);
        ev_t e;
        for (int b = 0; b < nbeats; b++) begin
            e.cyc  = tg + LAT * (b + 1);
            e.addr = base + 32'(4 * b);
            if (wr) begin
                e.kind = K_WR;
                e.data = 32'h100 + 32'(b);
            end else begin
                e.kind = is_dc ? K_DC_RV : K_IC_RV;
                e.data = e.addr ^ 32'hA5A5_A5A5;
            end
            sb.push_back(e);
        end
        if (with_done) begin
            e.kind = is_dc ? K_DC_DONE : K_IC_DONE;
            e.cyc  = tg + LAT * LW;
            e.addr = base + 32'(4 * (LW - 1));
            e.data = 32'h0;
            sb.push_back(e);
        end
    endtask

    task automatic sb_pop(input int kind, input logic [31:0] addr, input logic [31:0] data);
        ev_t e;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL sb_unexpected: observed event kind %0d at cycle %0d, expected none",
                   kind, cyc);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_kind", kind, e.kind);
            chk("sb_cycle", cyc, e.cyc);
            chk("sb_addr", addr, e.addr);
            if (kind < K_IC_DONE) chk("sb_data", data, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (bus.ic_rvalid_o === 1'b1) sb_pop(K_IC_RV, bus.mem_addr_o, bus.ic_rdata_o);
        if (bus.dc_rvalid_o === 1'b1) sb_pop(K_DC_RV, bus.mem_addr_o, bus.dc_rdata_o);
        if (bus.mem_we_o === 1'b1)    sb_pop(K_WR, bus.mem_addr_o, bus.mem_wdata_o);
        if (bus.ic_done_o === 1'b1)   sb_pop(K_IC_DONE, bus.mem_addr_o, 32'h0);
        if (bus.dc_done_o === 1'b1)   sb_pop(K_DC_DONE, bus.mem_addr_o, 32'h0);
    end

    initial begin
        bus.ic_req_i  = 1'b0;
        bus.ic_addr_i = '0;
        bus.dc_req_i  = 1'b0;
        bus.dc_we_i   = 1'b0;
        bus.dc_addr_i = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", bus.cache_stall_o, 1'b0);
        chk("rst_mem_en", bus.mem_en_o, 1'b0);
        chk("rst_mem_we", bus.mem_we_o, 1'b0);
        chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
        chk("rst_dc_beat", bus.dc_beat_o, 2'd0);
        chk("rst_ic_done", bus.ic_done_o, 1'b0);
        step();
        rst = 1'b0;

        // I-cache refill of the line holding 0x1004
        step();
        t0 = cyc;
        bus.ic_req_i  = 1'b1;
        bus.ic_addr_i = 32'h1004;
        expect_line(t0, 1'b0, 1'b0, 32'h1000, LW, 1'b1);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            chk("ic_stall", bus.cache_stall_o, 1'b1);
            chk("ic_mem_en", bus.mem_en_o, (k != 0));
            chk("ic_mem_addr", bus.mem_addr_o, (k == 0) ? 32'h0 : 32'h1000 + 32'(4 * ((k - 1) / 2)));
            chk("ic_dc_rdata", bus.dc_rdata_o, 32'h0);
            step();
            if (k == 8) bus.ic_req_i = 1'b0;
        end
        @(negedge clk);
        chk("ic_idle_stall", bus.cache_stall_o, 1'b0);
        chk("ic_idle_mem_en", bus.mem_en_o, 1'b0);
        chk("ic_drained", sb.size(), 0);

        // Simultaneous requests: D-cache first, I-cache arbitrated after one IDLE cycle
        step();
        t0 = cyc;
        bus.ic_req_i  = 1'b1;
        bus.ic_addr_i = 32'h1004;
        bus.dc_req_i  = 1'b1;
        bus.dc_we_i   = 1'b0;
        bus.dc_addr_i = 32'h2000;
        expect_line(t0, 1'b1, 1'b0, 32'h2000, LW, 1'b1);
        expect_line(t0 + 9, 1'b0, 1'b0, 32'h1000, LW, 1'b1);
        for (int k = 0; k <= 17; k++) begin
            @(negedge clk);
            chk("both_stall", bus.cache_stall_o, 1'b1);
            chk("both_mem_en", bus.mem_en_o, (k != 0 && k != 9));
            step();
            if (k == 8) bus.dc_req_i = 1'b0;
            if (k == 17) bus.ic_req_i = 1'b0;
        end
        @(negedge clk);
        chk("both_idle_stall", bus.cache_stall_o, 1'b0);
        chk("both_drained", sb.size(), 0);

        // D-cache writeback to 0x3000
        step();
        t0 = cyc;
        bus.dc_req_i  = 1'b1;
        bus.dc_we_i   = 1'b1;
        bus.dc_addr_i = 32'h3000;
        expect_line(t0, 1'b1, 1'b1, 32'h3000, LW, 1'b1);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            chk("wr_mem_we", bus.mem_we_o, (k >= 2 && k % 2 == 0));
            chk("wr_dc_beat", bus.dc_beat_o, (k == 0) ? 2'd0 : 2'((k - 1) / 2));
            step();
            if (k == 8) begin
                bus.dc_req_i = 1'b0;
                bus.dc_we_i  = 1'b0;
            end
        end
        @(negedge clk);
        chk("wr_drained", sb.size(), 0);

        // Reset in cycle 5 of an I-cache refill
        step();
        t0 = cyc;
        bus.ic_req_i  = 1'b1;
        bus.ic_addr_i = 32'h1004;
        expect_line(t0, 1'b0, 1'b0, 32'h1000, 2, 1'b0);
        repeat (5) step();
        rst          = 1'b1;
        bus.ic_req_i = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_mem_en", bus.mem_en_o, 1'b0);
        chk("abort_mem_addr", bus.mem_addr_o, 32'h0);
        chk("abort_stall", bus.cache_stall_o, 1'b0);
        chk("abort_ic_rvalid", bus.ic_rvalid_o, 1'b0);
        chk("abort_ic_done", bus.ic_done_o, 1'b0);
        repeat (10) step();
        chk("abort_drained", sb.size(), 0);
        t0 = cyc;
        bus.ic_req_i = 1'b1;
        expect_line(t0, 1'b0, 1'b0, 32'h1000, LW, 1'b1);
        repeat (9) step();
        bus.ic_req_i = 1'b0;
        step();
        chk("after_abort_drained", sb.size(), 0);

        // Both requesting continuously for four transfers
        t0 = cyc;
        bus.ic_req_i  = 1'b1;
        bus.dc_req_i  = 1'b1;
        bus.dc_addr_i = 32'h2000;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
            if (i % 2 == 0) expect_line(t0 + 9 * i, 1'b1, 1'b0, 32'h2000, LW, 1'b1);
            else            expect_line(t0 + 9 * i, 1'b0, 1'b0, 32'h1000, LW, 1'b1);
`else
            expect_line(t0 + 9 * i, 1'b1, 1'b0, 32'h2000, LW, 1'b1);
`endif
        end
        repeat (36) step();
        bus.ic_req_i = 1'b0;
        bus.dc_req_i = 1'b0;
        step();
        @(negedge clk);
        chk("cont_drained", sb.size(), 0);
        chk("cont_mem_en", bus.mem_en_o, 1'b0);

        // No requests
        for (int k = 0; k < 10; k++) begin
            step();
            @(negedge clk);
            chk("quiet_stall", bus.cache_stall_o, 1'b0);
            chk("quiet_mem_en", bus.mem_en_o, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
